puf_auth_verifier: RTL and testbench

Initiator and consumer for the ring-oscillator PUF's challenge/response interface. It generates a deterministic challenge sequence and drives the PUF's enable and 8-bit challenge. It captures each 8-bit response on the PUF ready handshake. In enroll mode it stores the responses; in verify mode it compares them against the stored set by Hamming distance and reports pass/fail.

---
 rtl/puf_auth_verifier.sv | 244 ++++++++++++++++++++++++
 tb/tb_puf_auth_verifier.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_auth_verifier.sv
// puf_auth_verifier: drives a ring-oscillator PUF with a deterministic LFSR
// challenge sequence, captures each response on the rising edge of puf_ready,
// and either enrolls the responses into a small table or verifies fresh
// responses against it by summed Hamming distance.
//
// Optional build macro PUF_VERIFY_MAJORITY_EN: when defined, every challenge is
// issued three times and the bitwise 2-of-3 majority of the responses is used.
module puf_auth_verifier #(
    parameter int         NUM_CHAL  = 4,
    parameter int         HD_THRESH = 1,
    parameter int         TIMEOUT   = 1023,
    parameter logic [7:0] SEED      = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode,
    output logic       puf_en,
    output logic [7:0] puf_chall,
    input  logic [7:0] puf_response,
    input  logic       puf_ready,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       fail_timeout,
    output logic [7:0] hd_total,
    output logic       enrolled
);

    localparam int                IDX_W    = (NUM_CHAL > 1) ? $clog2(NUM_CHAL) : 1;
    localparam int                DEPTH    = 1 << IDX_W;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_CHAL - 1);
    localparam logic [8:0]        HD_LIM   = 9'(HD_THRESH);
    localparam logic [9:0]        TO_LIM   = 10'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_RDY,
        CAPTURE,
        WAIT_LOW,
        FINISH
    } state_t;

    state_t           state_reg;
    logic             mode_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [7:0]       lfsr_reg;
    logic [7:0]       resp_reg;
    logic [7:0]       tbl_rd_reg;
    logic [9:0]       tcnt_reg;
    logic             ready_prev_reg;
    logic [7:0]       table_mem [DEPTH];

    logic             ready_rise;
    logic             timeout_hit;
    logic             last_rep;
    logic             tbl_we;
    logic [7:0]       final_resp;
    logic [7:0]       lfsr_next;
    logic [3:0]       hd_inc;
    logic [8:0]       hd_sum;
    logic [7:0]       hd_sat;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

`ifdef PUF_VERIFY_MAJORITY_EN
    logic [1:0] rep_reg;
    logic [7:0] samp0_reg;
    logic [7:0] samp1_reg;

    // The third capture of a challenge completes the vote
    assign last_rep   = (rep_reg == 2'd2);
    assign final_resp = (samp0_reg & samp1_reg) | (samp0_reg & resp_reg) | (samp1_reg & resp_reg);
`else
    assign last_rep   = 1'b1;
    assign final_resp = resp_reg;
`endif

    // Edge detect: a level that was already high when waiting began is not a response
    assign ready_rise  = puf_ready & ~ready_prev_reg;
    assign timeout_hit = (tcnt_reg == TO_LIM);
    assign lfsr_next   = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    assign hd_inc      = popcount8(final_resp ^ tbl_rd_reg);
    assign hd_sum      = {1'b0, hd_total} + {5'd0, hd_inc};
    assign hd_sat      = hd_sum[8] ? 8'hFF : hd_sum[7:0];
    assign tbl_we      = (state_reg == CAPTURE) && !mode_reg && last_rep;

    // Enrolled-response table, one register per entry so reset can clear it
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tbl
            always_ff @(posedge clk) begin
                if (rst) begin
                    table_mem[gi] <= 8'd0;
                end else if (tbl_we && (idx_reg == IDX_W'(gi))) begin
                    table_mem[gi] <= final_resp;
                end
            end
        end
    endgenerate

    // Registered table read; the index is stable long before CAPTURE uses it
    always_ff @(posedge clk) begin
        if (rst) begin
            tbl_rd_reg <= 8'd0;
        end else begin
            tbl_rd_reg <= table_mem[idx_reg];
        end
    end

    // Run sequencer with registered PUF handshake and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            mode_reg       <= 1'b0;
            idx_reg        <= '0;
            lfsr_reg       <= 8'd0;
            resp_reg       <= 8'd0;
            tcnt_reg       <= 10'd0;
            ready_prev_reg <= 1'b0;
            puf_en         <= 1'b0;
            puf_chall      <= 8'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_timeout   <= 1'b0;
            hd_total       <= 8'd0;
            enrolled       <= 1'b0;
`ifdef PUF_VERIFY_MAJORITY_EN
            rep_reg        <= 2'd0;
            samp0_reg      <= 8'd0;
            samp1_reg      <= 8'd0;
`endif
        end else begin
            ready_prev_reg <= puf_ready;
            done           <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mode_reg     <= mode;
                        pass         <= 1'b0;
                        fail_timeout <= 1'b0;
                        hd_total     <= 8'd0;
                        idx_reg      <= '0;
                        lfsr_reg     <= SEED;
                        busy         <= 1'b1;
`ifdef PUF_VERIFY_MAJORITY_EN
                        rep_reg      <= 2'd0;
`endif
                        // Verifying against an empty table can only fail
                        state_reg    <= (mode && !enrolled) ? FINISH : ISSUE;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ISSUE: begin
                    puf_chall <= lfsr_reg;
                    puf_en    <= 1'b1;
                    tcnt_reg  <= 10'd0;
                    state_reg <= WAIT_RDY;
                end
                WAIT_RDY: begin
                    if (ready_rise) begin
                        resp_reg  <= puf_response;
                        state_reg <= CAPTURE;
                    end else if (timeout_hit) begin
                        fail_timeout <= 1'b1;
                        pass         <= 1'b0;
                        puf_en       <= 1'b0;
                        state_reg    <= FINISH;
                    end else begin
                        tcnt_reg <= tcnt_reg + 10'd1;
                    end
                end
                CAPTURE: begin
                    if (last_rep && mode_reg) begin
                        hd_total <= hd_sat;
                    end
`ifdef PUF_VERIFY_MAJORITY_EN
                    if (rep_reg == 2'd0) begin
                        samp0_reg <= resp_reg;
                    end else if (rep_reg == 2'd1) begin
                        samp1_reg <= resp_reg;
                    end
`endif
                    puf_en    <= 1'b0;
                    tcnt_reg  <= 10'd0;
                    state_reg <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!puf_ready) begin
`ifdef PUF_VERIFY_MAJORITY_EN
                        if (!last_rep) begin
                            rep_reg   <= rep_reg + 2'd1;
                            state_reg <= ISSUE;
                        end else begin
                            rep_reg <= 2'd0;
`else
                        begin
`endif
                            if (idx_reg == IDX_LAST) begin
                                state_reg <= FINISH;
                            end else begin
                                lfsr_reg  <= lfsr_next;
                                idx_reg   <= idx_reg + 1'b1;
                                state_reg <= ISSUE;
                            end
                        end
                    end else if (timeout_hit) begin
                        fail_timeout <= 1'b1;
                        pass         <= 1'b0;
                        puf_en       <= 1'b0;
                        state_reg    <= FINISH;
                    end else begin
                        tcnt_reg <= tcnt_reg + 10'd1;
                    end
                end
                FINISH: begin
                    done      <= 1'b1;
                    state_reg <= IDLE;
                    if (!mode_reg) begin
                        // A partially rewritten table is not trustworthy
                        enrolled <= !fail_timeout;
                        pass     <= !fail_timeout;
                        hd_total <= 8'd0;
                    end else begin
                        pass <= !fail_timeout && enrolled && ({1'b0, hd_total} <= HD_LIM);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_auth_verifier.sv
// tb_puf_auth_verifier: directed bench for puf_auth_verifier with a behavioural
// PUF whose response is challenge ^ 8'h3C plus an optional per-challenge flip.
module tb_puf_auth_verifier;

    localparam int TIMEOUT = 1023;

    logic       clk;
    logic       rst;
    logic       start;
    logic       mode;
    logic       puf_en;
    logic [7:0] puf_chall;
    logic [7:0] puf_response;
    logic       puf_ready;
    logic       busy;
    logic       done;
    logic       pass;
    logic       fail_timeout;
    logic [7:0] hd_total;
    logic       enrolled;

    int checks   = 0;
    int failures = 0;

    // PUF model controls and observations
    int         n_chall     = 0;
    int         flip_idx    = -1;
    logic [7:0] flip_mask   = 8'h00;
    logic       never_ready = 1'b0;
    logic [7:0] chall_seen [8];
    int         en_cycles   = 0;

    puf_auth_verifier #(
        .NUM_CHAL (4),
        .HD_THRESH(1),
        .TIMEOUT  (TIMEOUT),
        .SEED     (8'hA5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .puf_en      (puf_en),
        .puf_chall   (puf_chall),
        .puf_response(puf_response),
        .puf_ready   (puf_ready),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .fail_timeout(fail_timeout),
        .hd_total    (hd_total),
        .enrolled    (enrolled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (puf_en === 1'b1) en_cycles++;
    end

    // Behavioural PUF: ready rises 20 cycles after enable, falls 5 cycles after enable drops
    initial begin
        int cur;
        puf_ready    = 1'b0;
        puf_response = 8'h00;
        forever begin
            @(negedge clk);
            if (puf_en === 1'b1) begin
                cur = n_chall;
                if (n_chall < 8) chall_seen[n_chall] = puf_chall;
                n_chall++;
                for (int k = 0; k < 19 && puf_en === 1'b1; k++) @(negedge clk);
                if (!never_ready && puf_en === 1'b1) begin
                    puf_response = puf_chall ^ 8'h3C ^ ((cur == flip_idx) ? flip_mask : 8'h00);
                    puf_ready    = 1'b1;
                    for (int k = 0; k < 100 && puf_en === 1'b1; k++) @(negedge clk);
                    repeat (5) @(negedge clk);
                    puf_ready = 1'b0;
                end else begin
                    for (int k = 0; k < 3000 && puf_en === 1'b1; k++) @(negedge clk);
                end
            end
        end
    end

    // Start a run, holding start for 'hold' cycles and flipping mode right after start
    task automatic do_run(input logic m, input int hold, output int cyc, output int seen);
        @(negedge clk);
        n_chall   = 0;
        en_cycles = 0;
        start     = 1'b1;
        mode      = m;
        cyc       = 0;
        seen      = 0;
        while (cyc < 5000 && seen == 0) begin
            @(negedge clk);
            cyc++;
            if (cyc >= hold) start = 1'b0;
            if (cyc == 1) mode = ~m;
            if (done === 1'b1) seen = 1;
        end
        start = 1'b0;
        checks++;
        if (seen == 0) begin
            failures++;
            $display("FAIL run_done_timeout: done not seen after %0d cycles, required within 5000", cyc);
        end
    endtask

    task automatic test_reset;
        int cyc, seen;
        rst = 1'b1; start = 1'b0; mode = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({puf_en, puf_chall, busy, done, pass, fail_timeout, hd_total, enrolled} !== 20'd0) begin
            failures++;
            $display("FAIL reset_outputs: got en=%b chall=%h busy=%b done=%b pass=%b fto=%b hd=%0d enr=%b, required all 0",
                     puf_en, puf_chall, busy, done, pass, fail_timeout, hd_total, enrolled);
        end
        rst = 1'b0;
        do_run(1'b1, 1, cyc, seen);
        checks++;
        if (cyc !== 2) begin
            failures++;
            $display("FAIL unenrolled_done_latency: got %0d cycles, required 2", cyc);
        end
        checks++;
        if (pass !== 1'b0) begin
            failures++;
            $display("FAIL unenrolled_pass: got %b, required 0", pass);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL unenrolled_after: got busy=%b done=%b, required 0 0", busy, done);
        end
        $display("test_reset: unenrolled verify done after %0d cycles pass=%b", cyc, pass);
    endtask

    task automatic test_enroll;
        int cyc, seen;
        logic [7:0] exp_chall [4];
        exp_chall[0] = 8'hA5; exp_chall[1] = 8'h4A; exp_chall[2] = 8'h95; exp_chall[3] = 8'h2A;
        flip_idx = -1;
        do_run(1'b0, 1, cyc, seen);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (chall_seen[i] !== exp_chall[i]) begin
                failures++;
                $display("FAIL enroll_chall%0d: got %h, required %h", i, chall_seen[i], exp_chall[i]);
            end
        end
        checks++;
        if (n_chall !== 4) begin
            failures++;
            $display("FAIL enroll_count: got %0d challenges, required 4", n_chall);
        end
        checks++;
        if (pass !== 1'b1 || enrolled !== 1'b1 || fail_timeout !== 1'b0) begin
            failures++;
            $display("FAIL enroll_status: got pass=%b enr=%b fto=%b, required 1 1 0", pass, enrolled, fail_timeout);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL enroll_done_width: done still %b a cycle later, required 0", done);
        end
        $display("test_enroll: challenges %h %h %h %h pass=%b enrolled=%b",
                 chall_seen[0], chall_seen[1], chall_seen[2], chall_seen[3], pass, enrolled);
    endtask

    task automatic test_verify;
        int cyc, seen;
        flip_idx = -1;
        do_run(1'b1, 1, cyc, seen);
        checks++;
        if (pass !== 1'b1 || hd_total !== 8'd0) begin
            failures++;
            $display("FAIL verify_exact: got pass=%b hd=%0d, required 1 0", pass, hd_total);
        end
        $display("test_verify: exact responses hd=%0d pass=%b", hd_total, pass);
        flip_idx = 2; flip_mask = 8'h01;
        do_run(1'b1, 1, cyc, seen);
        checks++;
        if (pass !== 1'b1 || hd_total !== 8'd1) begin
            failures++;
            $display("FAIL verify_hd1: got pass=%b hd=%0d, required 1 1", pass, hd_total);
        end
        $display("test_verify: one flipped bit hd=%0d pass=%b", hd_total, pass);
    endtask

    task automatic test_verify_hd2;
        int cyc, seen;
        flip_idx = 1; flip_mask = 8'h81;
        do_run(1'b1, 1, cyc, seen);
        checks++;
        if (pass !== 1'b0 || hd_total !== 8'd2 || fail_timeout !== 1'b0) begin
            failures++;
            $display("FAIL verify_hd2: got pass=%b hd=%0d fto=%b, required 0 2 0", pass, hd_total, fail_timeout);
        end
        checks++;
        if (enrolled !== 1'b1) begin
            failures++;
            $display("FAIL verify_keeps_enrolled: got %b, required 1", enrolled);
        end
        $display("test_verify_hd2: hd=%0d pass=%b", hd_total, pass);
        flip_idx = -1;
    endtask

    task automatic test_timeout;
        int cyc, seen;
        never_ready = 1'b1;
        do_run(1'b1, 1, cyc, seen);
        checks++;
        if (fail_timeout !== 1'b1 || pass !== 1'b0) begin
            failures++;
            $display("FAIL timeout_status: got fto=%b pass=%b, required 1 0", fail_timeout, pass);
        end
        checks++;
        if (en_cycles < TIMEOUT || en_cycles > TIMEOUT + 2) begin
            failures++;
            $display("FAIL timeout_wait_len: got %0d enable cycles, required %0d..%0d", en_cycles, TIMEOUT, TIMEOUT + 2);
        end
        checks++;
        if (puf_en !== 1'b0 || n_chall !== 1) begin
            failures++;
            $display("FAIL timeout_en: got en=%b issues=%0d, required 0 1", puf_en, n_chall);
        end
        $display("test_timeout: en_cycles=%0d fto=%b pass=%b", en_cycles, fail_timeout, pass);
        never_ready = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_midrun;
        int stray;
        @(negedge clk);
        n_chall = 0;
        start = 1'b1; mode = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (puf_en !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midrun_active: got en=%b busy=%b, required 1 1", puf_en, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (puf_en !== 1'b0 || busy !== 1'b0 || enrolled !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset: got en=%b busy=%b enr=%b done=%b, required 0 0 0 0",
                     puf_en, busy, enrolled, done);
        end
        rst = 1'b0;
        stray = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) stray++;
        end
        checks++;
        if (stray !== 0) begin
            failures++;
            $display("FAIL midrun_no_done: got %0d cycles with done/busy, required 0", stray);
        end
        $display("test_reset_midrun: en=%b busy=%b enrolled=%b stray=%0d", puf_en, busy, enrolled, stray);
    endtask

    task automatic test_start_while_busy;
        int cyc, seen, extra;
        flip_idx = -1;
        do_run(1'b0, 1, cyc, seen);
        flip_idx = 0; flip_mask = 8'h01;
        do_run(1'b1, 12, cyc, seen);
        checks++;
        if (n_chall !== 4 || hd_total !== 8'd1 || pass !== 1'b1) begin
            failures++;
            $display("FAIL busy_start: got issues=%0d hd=%0d pass=%b, required 4 1 1", n_chall, hd_total, pass);
        end
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL busy_extra_done: got %0d further done pulses, required 0", extra);
        end
        $display("test_start_while_busy: issues=%0d hd=%0d pass=%b", n_chall, hd_total, pass);
        flip_idx = -1;
    endtask

    initial begin
        test_reset();
        test_enroll();
        test_verify();
        test_verify_hd2();
        test_timeout();
        test_reset_midrun();
        test_start_while_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
